// File: rtl/red_ctrl_seq_if.sv
// Instruction fetch bus between red_ctrl_seq (master) and the instruction
// memory (slave). The master holds req/addr stable until the slave returns
// valid together with the instruction word.
interface red_ctrl_seq_if #(
   parameter int DATA_WIDTH = 32,
   parameter int PC_WIDTH   = 32
);
   logic                  instr_req;
   logic [PC_WIDTH-1:0]   instr_addr;
   logic                  instr_valid;
   logic [DATA_WIDTH-1:0] instr;

   modport master (
      output instr_req,
      output instr_addr,
      input  instr_valid,
      input  instr
   );

   modport slave (
      input  instr_req,
      input  instr_addr,
      output instr_valid,
      output instr
   );
endinterface

// File: rtl/red_ctrl_seq.sv
// Control sequencer for the reduced RISC-V register/ALU datapath.
// Fetches over red_ctrl_seq_if, decodes addi/add/sub/beq/bne, resolves
// branches from EQ and halts on ebreak or any unsupported encoding.
// Optional retired-instruction counter: define RED_PERF_CNT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for run after reset
// S_FETCH | instr_req high at PC, waiting for instr_valid
// S_EXEC  | one cycle; decode drives datapath, PC/regfile update at end
// S_HALT  | stopped (ebreak or illegal); left only through reset
module red_ctrl_seq #(
   parameter int                 DATA_WIDTH    = 32,
   parameter int                 ADDRESS_WIDTH = 5,
   parameter int                 ALUctrl_WIDTH = 3,
   parameter int                 PC_WIDTH      = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC     = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     run,
   red_ctrl_seq_if.master           fetch,
   input  logic                     EQ,
   output logic [DATA_WIDTH-1:0]    ImmOp,
   output logic                     RegWrite,
   output logic [ALUctrl_WIDTH-1:0] ALUctrl,
   output logic                     ALUsrc,
   output logic [ADDRESS_WIDTH-1:0] rs1,
   output logic [ADDRESS_WIDTH-1:0] rs2,
   output logic [ADDRESS_WIDTH-1:0] rd,
   output logic                     halt,
   output logic                     illegal,
   output logic [31:0]              retired
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;
   typedef enum logic [2:0] {OP_ADDI, OP_ADD, OP_SUB, OP_BEQ, OP_BNE, OP_EBREAK, OP_ILL} op_t;

   state_t                state;
   logic [PC_WIDTH-1:0]   pc;
   logic [DATA_WIDTH-1:0] ir;
   op_t                   op;
   logic [DATA_WIDTH-1:0] imm_i;
   logic [DATA_WIDTH-1:0] imm_b;
   logic                  br_taken;
   logic [PC_WIDTH-1:0]   pc_next;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = ir[6:0];
   assign funct3 = ir[14:12];
   assign funct7 = ir[31:25];

   assign imm_i = {{(DATA_WIDTH-12){ir[31]}}, ir[31:20]};
   assign imm_b = {{(DATA_WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

   assign fetch.instr_req  = (state == S_FETCH);
   assign fetch.instr_addr = pc;

   // Classify the latched instruction; anything not recognised is illegal.
   always_comb begin
      op = OP_ILL;
      if (ir == DATA_WIDTH'(32'h0010_0073)) begin
         op = OP_EBREAK;
      end else begin
         case (opcode)
            7'b0010011: if (funct3 == 3'b000) op = OP_ADDI;
            7'b0110011: begin
               if (funct3 == 3'b000 && funct7 == 7'b0000000)      op = OP_ADD;
               else if (funct3 == 3'b000 && funct7 == 7'b0100000) op = OP_SUB;
            end
            7'b1100011: begin
               if (funct3 == 3'b000)      op = OP_BEQ;
               else if (funct3 == 3'b001) op = OP_BNE;
            end
            default: op = OP_ILL;
         endcase
      end
   end

   // Datapath controls, live only in EXEC; everything else sees zeros.
   always_comb begin
      ImmOp    = '0;
      RegWrite = 1'b0;
      ALUctrl  = '0;
      ALUsrc   = 1'b0;
      rs1      = '0;
      rs2      = '0;
      rd       = '0;
      if (state == S_EXEC) begin
         case (op)
            OP_ADDI: begin
               ImmOp    = imm_i;
               RegWrite = 1'b1;
               ALUsrc   = 1'b1;
               rs1      = ADDRESS_WIDTH'(ir[19:15]);
               rd       = ADDRESS_WIDTH'(ir[11:7]);
            end
            OP_ADD, OP_SUB: begin
               RegWrite = 1'b1;
               ALUctrl  = (op == OP_SUB) ? ALUctrl_WIDTH'(1) : '0;
               rs1      = ADDRESS_WIDTH'(ir[19:15]);
               rs2      = ADDRESS_WIDTH'(ir[24:20]);
               rd       = ADDRESS_WIDTH'(ir[11:7]);
            end
            OP_BEQ, OP_BNE: begin
               ImmOp    = imm_b;
               ALUctrl  = ALUctrl_WIDTH'(1);
               rs1      = ADDRESS_WIDTH'(ir[19:15]);
               rs2      = ADDRESS_WIDTH'(ir[24:20]);
            end
            default: ;
         endcase
      end
   end

   // Next PC: branch target when taken, else sequential; wraps naturally.
   always_comb begin
      br_taken = ((op == OP_BEQ) && EQ) || ((op == OP_BNE) && !EQ);
      pc_next  = br_taken ? (pc + PC_WIDTH'(signed'(imm_b))) : (pc + PC_WIDTH'(4));
   end

   // Sequencer FSM: fetch, execute, halt; PC/IR/status are all registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         pc      <= RESET_PC;
         ir      <= '0;
         halt    <= 1'b0;
         illegal <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (run) state <= S_FETCH;
            end
            S_FETCH: begin
               if (fetch.instr_valid) begin
                  ir    <= fetch.instr;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (op == OP_EBREAK) begin
                  halt  <= 1'b1;
                  state <= S_HALT;
               end else if (op == OP_ILL) begin
                  halt    <= 1'b1;
                  illegal <= 1'b1;
                  state   <= S_HALT;
               end else begin
                  pc    <= pc_next;
                  state <= S_FETCH;
               end
            end
            S_HALT: begin
               halt <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef RED_PERF_CNT_EN
   // Count every legal non-ebreak instruction as it leaves EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired <= '0;
      end else if (state == S_EXEC && op != OP_EBREAK && op != OP_ILL) begin
         retired <= retired + 32'd1;
      end
   end
`else
   assign retired = '0;
`endif

endmodule

// File: tb/tb_red_ctrl_seq.sv
// Directed bench for red_ctrl_seq: drives the fetch bus by hand and checks
// decode, branch, wait-state, halt and reset behaviour.
module tb_red_ctrl_seq;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic        EQ;
   logic [31:0] ImmOp;
   logic        RegWrite;
   logic [2:0]  ALUctrl;
   logic        ALUsrc;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic        halt;
   logic        illegal;
   logic [31:0] retired;

   int checks = 0;
   int errors = 0;

   red_ctrl_seq_if #(.DATA_WIDTH(32), .PC_WIDTH(32)) fetch ();

   red_ctrl_seq dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .fetch    (fetch.master),
      .EQ       (EQ),
      .ImmOp    (ImmOp),
      .RegWrite (RegWrite),
      .ALUctrl  (ALUctrl),
      .ALUsrc   (ALUsrc),
      .rs1      (rs1),
      .rs2      (rs2),
      .rd       (rd),
      .halt     (halt),
      .illegal  (illegal),
      .retired  (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next falling edge.
   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   // In FETCH: check the request, present a zero-wait instruction, land in EXEC.
   task automatic feed(input string tag, input logic [31:0] addr, input logic [31:0] word);
      chk({tag, "_req"}, {31'd0, fetch.instr_req}, 32'd1);
      chk({tag, "_addr"}, fetch.instr_addr, addr);
      fetch.instr_valid = 1'b1;
      fetch.instr       = word;
      cyc();
      fetch.instr_valid = 1'b0;
      fetch.instr       = 32'hDEAD_BEEF;
   endtask

   task automatic start();
      cyc();
      run = 1'b1;
      cyc();
      run = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_ret;
      rst_n = 1'b0;
      run   = 1'b0;
      EQ    = 1'b0;
      fetch.instr_valid = 1'b0;
      fetch.instr       = 32'h0;
      #3;
      chk("rst_req",      {31'd0, fetch.instr_req}, 32'd0);
      chk("rst_addr",     fetch.instr_addr, 32'h0);
      chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
      chk("rst_immop",    ImmOp, 32'h0);
      chk("rst_halt",     {31'd0, halt}, 32'd0);
      chk("rst_illegal",  {31'd0, illegal}, 32'd0);
      chk("rst_retired",  retired, 32'h0);
      cyc();
      rst_n = 1'b1;
      cyc();
      chk("idle_req", {31'd0, fetch.instr_req}, 32'd0);
      start();

      // addi a0,x0,5
      feed("addi5", 32'h0, 32'h0050_0513);
      chk("addi5_regwrite", {31'd0, RegWrite}, 32'd1);
      chk("addi5_alusrc",   {31'd0, ALUsrc}, 32'd1);
      chk("addi5_immop",    ImmOp, 32'd5);
      chk("addi5_rd",       {27'd0, rd}, 32'd10);
      chk("addi5_rs1",      {27'd0, rs1}, 32'd0);
      chk("addi5_aluctrl",  {29'd0, ALUctrl}, 32'd0);
      chk("addi5_req",      {31'd0, fetch.instr_req}, 32'd0);
      cyc();

      // addi a0,x0,-1
      feed("addim1", 32'h4, 32'hFFF0_0513);
      chk("addim1_immop",    ImmOp, 32'hFFFF_FFFF);
      chk("addim1_regwrite", {31'd0, RegWrite}, 32'd1);
      cyc();
      chk("addim1_regwrite_off", {31'd0, RegWrite}, 32'd0);

      // bne a0,x0,-4 at 8, EQ=0 -> taken to 4
      EQ = 1'b0;
      feed("bne_nt", 32'h8, 32'hFE05_1EE3);
      chk("bne_regwrite", {31'd0, RegWrite}, 32'd0);
      chk("bne_aluctrl",  {29'd0, ALUctrl}, 32'd1);
      chk("bne_alusrc",   {31'd0, ALUsrc}, 32'd0);
      chk("bne_immop",    ImmOp, 32'hFFFF_FFFC);
      chk("bne_rs1",      {27'd0, rs1}, 32'd10);
      chk("bne_rd",       {27'd0, rd}, 32'd0);
      cyc();

      // add x3,x1,x2 at 4
      feed("add", 32'h4, 32'h0020_81B3);
      chk("add_regwrite", {31'd0, RegWrite}, 32'd1);
      chk("add_alusrc",   {31'd0, ALUsrc}, 32'd0);
      chk("add_aluctrl",  {29'd0, ALUctrl}, 32'd0);
      chk("add_rs1",      {27'd0, rs1}, 32'd1);
      chk("add_rs2",      {27'd0, rs2}, 32'd2);
      chk("add_rd",       {27'd0, rd}, 32'd3);
      chk("add_immop",    ImmOp, 32'h0);
      cyc();

      // bne at 8 with EQ=1 -> not taken, falls to 12
      EQ = 1'b1;
      feed("bne_eq", 32'h8, 32'hFE05_1EE3);
      chk("bne_eq_regwrite", {31'd0, RegWrite}, 32'd0);
      cyc();
      EQ = 1'b0;

      // sub x5,x6,x7 at 12
      feed("sub", 32'hC, 32'h4073_02B3);
      chk("sub_aluctrl",  {29'd0, ALUctrl}, 32'd1);
      chk("sub_regwrite", {31'd0, RegWrite}, 32'd1);
      chk("sub_rd",       {27'd0, rd}, 32'd5);
      cyc();

      // three wait states at 0x10, then lw (illegal)
      for (int i = 0; i < 3; i++) begin
         chk("wait_req",      {31'd0, fetch.instr_req}, 32'd1);
         chk("wait_addr",     fetch.instr_addr, 32'h10);
         chk("wait_regwrite", {31'd0, RegWrite}, 32'd0);
         cyc();
      end
      feed("lw", 32'h10, 32'h0000_2003);
      chk("lw_regwrite", {31'd0, RegWrite}, 32'd0);
      chk("lw_halt_pre", {31'd0, halt}, 32'd0);
      cyc();
      run = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("lw_halt",     {31'd0, halt}, 32'd1);
         chk("lw_illegal",  {31'd0, illegal}, 32'd1);
         chk("lw_req",      {31'd0, fetch.instr_req}, 32'd0);
         chk("lw_addr",     fetch.instr_addr, 32'h10);
         chk("lw_regwrite", {31'd0, RegWrite}, 32'd0);
         cyc();
      end
      run = 1'b0;
`ifdef RED_PERF_CNT_EN
      exp_ret = 32'd6;
`else
      exp_ret = 32'd0;
`endif
      chk("lw_retired", retired, exp_ret);

      // Reset, then beq x0,x0,-4 at 0 taken -> wrap to 0xFFFFFFFC
      rst_n = 1'b0;
      #1;
      chk("rst2_halt",    {31'd0, halt}, 32'd0);
      chk("rst2_illegal", {31'd0, illegal}, 32'd0);
      chk("rst2_addr",    fetch.instr_addr, 32'h0);
      cyc();
      rst_n = 1'b1;
      start();
      EQ = 1'b1;
      feed("beq", 32'h0, 32'hFE00_0EE3);
      chk("beq_immop", ImmOp, 32'hFFFF_FFFC);
      cyc();
      EQ = 1'b0;
      feed("wrap", 32'hFFFF_FFFC, 32'h0010_0093);
      chk("wrap_rd", {27'd0, rd}, 32'd1);
      cyc();
      feed("wrap0", 32'h0, 32'h0010_0093);
      cyc();
      feed("mid", 32'h4, 32'h0030_0093);
      chk("mid_regwrite", {31'd0, RegWrite}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_regwrite", {31'd0, RegWrite}, 32'd0);
      chk("midrst_addr",     fetch.instr_addr, 32'h0);
      chk("midrst_req",      {31'd0, fetch.instr_req}, 32'd0);
      cyc();
      rst_n = 1'b1;
      cyc();
      cyc();
      chk("midrst_idle_req", {31'd0, fetch.instr_req}, 32'd0);
      chk("midrst_idle_addr", fetch.instr_addr, 32'h0);

      // addi, addi, ebreak
      start();
      feed("p1", 32'h0, 32'h0010_0093);
      cyc();
      feed("p2", 32'h4, 32'h0020_0113);
      cyc();
      feed("ebreak", 32'h8, 32'h0010_0073);
      chk("ebreak_regwrite", {31'd0, RegWrite}, 32'd0);
      cyc();
      chk("ebreak_halt",    {31'd0, halt}, 32'd1);
      chk("ebreak_illegal", {31'd0, illegal}, 32'd0);
      chk("ebreak_addr",    fetch.instr_addr, 32'h8);
      chk("ebreak_req",     {31'd0, fetch.instr_req}, 32'd0);
`ifdef RED_PERF_CNT_EN
      exp_ret = 32'd2;
`else
      exp_ret = 32'd0;
`endif
      chk("ebreak_retired", retired, exp_ret);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/red_ctrl_seq.md
Name: red_ctrl_seq

Overview:
Control sequencer for the reduced RISC-V register/ALU datapath. It holds the PC and fetches instructions from an external instruction memory over a req/valid handshake. It decodes each instruction and drives the datapath control inputs (ImmOp, RegWrite, ALUctrl, ALUsrc, rs1, rs2, rd), then resolves branches from the datapath EQ flag. It executes one instruction per FETCH→EXEC pass and halts on ebreak or an unsupported encoding.

Parameters:
DATA_WIDTH, 32, datapath and instruction width
ADDRESS_WIDTH, 5, register index width
ALUctrl_WIDTH, 3, ALU control width
PC_WIDTH, 32, program counter width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  start request, sampled only in IDLE
instr_req  output  1  fetch request
instr_addr  output  PC_WIDTH  fetch address (= PC)
instr_valid  input  1  instr valid this cycle
instr  input  DATA_WIDTH  instruction word
EQ  input  1  datapath equality flag (operands equal)
ImmOp  output  DATA_WIDTH  sign-extended immediate
RegWrite  output  1  register file write enable
ALUctrl  output  ALUctrl_WIDTH  000 add, 001 sub/compare
ALUsrc  output  1  1 = immediate operand, 0 = register operand
rs1  output  ADDRESS_WIDTH  source register 1
rs2  output  ADDRESS_WIDTH  source register 2
rd  output  ADDRESS_WIDTH  destination register
halt  output  1  sequencer stopped
illegal  output  1  stop caused by an unsupported instruction
retired  output  32  retired-instruction count (optional feature)

Behaviour:
- Reset is asynchronous on rst_n low.
  - Values: state=IDLE, PC=RESET_PC, IR=0, halt=0, illegal=0, retired=0.
  - RegWrite, instr_req, ImmOp, ALUctrl, ALUsrc, rs1, rs2 and rd are all 0 immediately.
- FSM transitions:
  - IDLE→FETCH when run=1. run is ignored in every other state.
  - FETCH: instr_req=1 and instr_addr=PC. When instr_valid=1, latch instr into IR and go to EXEC.
  - FETCH with zero-wait memory: valid in the first FETCH cycle gives a minimum of 2 cycles per instruction.
  - FETCH wait states: instr_req and instr_addr are held stable until valid.
  - instr_valid is ignored outside FETCH.
  - EXEC: exactly one cycle. Decode outputs are driven combinationally from IR.
  - EXEC, legal instruction: the register write (if any) and the PC update occur on the edge ending EXEC; next state FETCH.
  - HALT: halt=1, instr_req=0, RegWrite=0. Exit only via reset.
- RegWrite is 1 only in EXEC, for addi, add and sub. All control outputs are 0 outside EXEC.
- Decode:
  - addi (opcode 0010011, funct3 000): ALUsrc=1, ALUctrl=000, ImmOp=sext(instr[31:20]), rd/rs1 from the fields.
  - add/sub (opcode 0110011, funct3 000, funct7 0000000 or 0100000): ALUsrc=0, ALUctrl=000 or 001, ImmOp=0.
  - beq/bne (opcode 1100011, funct3 000 or 001): ALUsrc=0, ALUctrl=001, rd=0, RegWrite=0, ImmOp=sext B-immediate (13-bit, bit0=0).
  - ebreak (exactly 32'h00100073): enter HALT, illegal=0.
  - Any other encoding (other opcodes, funct3, funct7): enter HALT, illegal=1, RegWrite stays 0.
- PC update:
  - Branch resolution: EQ is sampled in EXEC. beq is taken when EQ=1; bne is taken when EQ=0.
  - Next PC: taken branch → PC+ImmOp; otherwise PC+4.
  - Arithmetic is modulo 2^PC_WIDTH, so 0xFFFFFFFC+4 wraps to 0.
  - On HALT the PC is not updated and keeps the address of the ebreak or offending instruction.
- Reset mid-EXEC or mid-FETCH: an async drop cancels the pending write and fetch immediately. No partial PC update.

Optional Feature:
RED_PERF_CNT_EN
- Defined: retired increments by 1 on each EXEC of a legal non-ebreak instruction (addi, add, sub, beq, bne). It wraps at 2^32 and resets to 0.
- Undefined: retired is tied to 0 and the counter logic is removed.

Test Plan:
- Reset, run=1, instr 0x00500513 (addi a0,x0,5) at PC 0, zero-wait → EXEC: RegWrite=1, ALUsrc=1, ImmOp=5, rd=10, rs1=0, ALUctrl=000. Next instr_addr=4.
- instr 0xFFF00513 (addi a0,x0,-1) → ImmOp=0xFFFFFFFF, RegWrite=1 for exactly one cycle.
- bne a0,x0,-4 (0xFE051EE3) at PC 8 with EQ=0 → next instr_addr=4. Same with EQ=1 → next instr_addr=12. RegWrite=0 in both cases.
- instr_valid delayed 3 cycles in FETCH → instr_req=1 and instr_addr constant for 4 cycles. RegWrite=0 throughout.
- instr 0x00002003 (lw) at PC 0x10 → halt=1, illegal=1, RegWrite never 1, instr_req=0 afterwards, instr_addr=0x10. run=1 has no effect.
- Program addi, addi, ebreak → halt=1, illegal=0, retired=2 with RED_PERF_CNT_EN defined. rst_n low mid-EXEC → RegWrite=0 immediately, instr_addr=RESET_PC, state IDLE.
